// File: rtl/apb_arb_pkg.sv
// apb_arb_pkg: shared state encoding and default parameters for the APB arbiter
package apb_arb_pkg;
   localparam int ADDR_W_DEF  = 8;
   localparam int DATA_W_DEF  = 32;
   localparam int TIMEOUT_DEF = 16;
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin grant with a last-grant register
module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       take,
   output logic       gnt
);
   logic last;
   // a tie goes to the port that did not win last; a lone requester always wins
   always_comb gnt = &req ? ~last : req[1];
   // port 1 counts as last winner out of reset so port 0 takes the first tie
   always_ff @(posedge clk)
      if (rst) last <= 1'b1;
      else if (take) last <= gnt;
endmodule

// File: rtl/apb_arbiter.sv
// apb_arbiter: two requesters sharing one APB master port with timeout
module apb_arbiter
   import apb_arb_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic              pclk_i,
   input  logic              preset_i,
   input  logic              req0_i,
   input  logic              req1_i,
   input  logic              wr0_i,
   input  logic              wr1_i,
   input  logic [ADDR_W-1:0] addr0_i,
   input  logic [ADDR_W-1:0] addr1_i,
   input  logic [DATA_W-1:0] wdata0_i,
   input  logic [DATA_W-1:0] wdata1_i,
   output logic              done0_o,
   output logic              done1_o,
   output logic [DATA_W-1:0] rdata0_o,
   output logic [DATA_W-1:0] rdata1_o,
   output logic              err0_o,
   output logic              err1_o,
   output logic              psel_o,
   output logic              penable_o,
   output logic              pwrite_o,
   output logic [ADDR_W-1:0] paddr_o,
   output logic [DATA_W-1:0] pwdata_o,
   input  logic [DATA_W-1:0] prdata_i,
   input  logic              pready_i,
   input  logic              pslverr_i
);
   state_t     state, nxt;
   logic [7:0] wcnt;
   logic       own, gnt, grant, fin, err;
   rr_arb2 u_arb (
      .clk (pclk_i),
      .rst (preset_i),
      .req ({req1_i, req0_i}),
      .take(grant),
      .gnt (gnt)
   );
   // next state: a transfer ends on pready or when the wait budget runs out
   always_comb begin
      grant = (state == IDLE) && (req0_i || req1_i);
      fin   = (state == ACCESS) && (pready_i || wcnt == 8'(TIMEOUT - 1));
      err   = ~pready_i | pslverr_i;
      nxt   = grant ? SETUP : state == SETUP ? ACCESS : fin ? IDLE : state;
   end
   // state, bus strobes and wait counter, strobes registered from next state
   always_ff @(posedge pclk_i)
      if (preset_i) begin
         state     <= IDLE;
         psel_o    <= 1'b0;
         penable_o <= 1'b0;
         wcnt      <= '0;
      end else begin
         state     <= nxt;
         psel_o    <= nxt != IDLE;
         penable_o <= nxt == ACCESS;
         wcnt      <= grant ? '0 : (state == ACCESS && !pready_i) ? wcnt + 8'd1 : wcnt;
      end
   // latch the winner's request on grant and return the response to its owner
   always_ff @(posedge pclk_i)
      if (preset_i) begin
         own      <= 1'b0;
         pwrite_o <= 1'b0;
         paddr_o  <= '0;
         pwdata_o <= '0;
         done0_o  <= 1'b0;
         done1_o  <= 1'b0;
         err0_o   <= 1'b0;
         err1_o   <= 1'b0;
         rdata0_o <= '0;
         rdata1_o <= '0;
      end else begin
         done0_o <= fin && !own;
         done1_o <= fin && own;
         if (grant) begin
            own      <= gnt;
            pwrite_o <= gnt ? wr1_i : wr0_i;
            paddr_o  <= gnt ? addr1_i : addr0_i;
            pwdata_o <= gnt ? wdata1_i : wdata0_i;
         end
         if (fin && !own) err0_o <= err;
         if (fin && own) err1_o <= err;
         if (fin && !own && pready_i && !pwrite_o) rdata0_o <= prdata_i;
         if (fin && own && pready_i && !pwrite_o) rdata1_o <= prdata_i;
      end
endmodule

// File: tb/tb_apb_arbiter.sv
// tb_apb_arbiter: directed and randomized check of apb_arbiter against a transaction-level model
module tb_apb_arbiter;
   localparam int AW = 8;
   localparam int DW = 32;
   localparam int TO = 16;

   logic          pclk_i_tb = 1'b0;
   logic          preset_i;
   logic          req0_i, req1_i, wr0_i, wr1_i;
   logic [AW-1:0] addr0_i, addr1_i;
   logic [DW-1:0] wdata0_i, wdata1_i;
   logic          done0_o, done1_o, err0_o, err1_o;
   logic [DW-1:0] rdata0_o, rdata1_o;
   logic          psel_o, penable_o, pwrite_o;
   logic [AW-1:0] paddr_o;
   logic [DW-1:0] pwdata_o;
   logic [DW-1:0] prdata_i;
   logic          pready_i, pslverr_i;

   apb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .pclk_i   (pclk_i_tb),
      .preset_i (preset_i),
      .req0_i   (req0_i),
      .req1_i   (req1_i),
      .wr0_i    (wr0_i),
      .wr1_i    (wr1_i),
      .addr0_i  (addr0_i),
      .addr1_i  (addr1_i),
      .wdata0_i (wdata0_i),
      .wdata1_i (wdata1_i),
      .done0_o  (done0_o),
      .done1_o  (done1_o),
      .rdata0_o (rdata0_o),
      .rdata1_o (rdata1_o),
      .err0_o   (err0_o),
      .err1_o   (err1_o),
      .psel_o   (psel_o),
      .penable_o(penable_o),
      .pwrite_o (pwrite_o),
      .paddr_o  (paddr_o),
      .pwdata_o (pwdata_o),
      .prdata_i (prdata_i),
      .pready_i (pready_i),
      .pslverr_i(pslverr_i)
   );

   always #5 pclk_i_tb = ~pclk_i_tb;

   int n_chk = 0;
   int n_fail = 0;

   logic [DW-1:0] mem [256];
   int            rdy_mode, stall;
   logic          err_addr_en, rand_err, force_prd_en;
   logic [DW-1:0] force_prd;
   int            psel_cnt, pen_cnt, d0_cnt, d1_cnt;
   int            order [$];

   // transaction-level model: an outstanding transfer, its owner and its age
   logic          m_busy, m_acc, m_own, m_last;
   int            m_wait;
   logic          e_psel, e_pen, e_pwrite;
   logic [AW-1:0] e_paddr;
   logic [DW-1:0] e_pwdata;
   logic [1:0]    e_done, e_err;
   logic [DW-1:0] e_rdata [2];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_step();
      logic g;
      if (preset_i) begin
         m_busy = 0; m_acc = 0; m_own = 0; m_last = 1; m_wait = 0;
         e_pwrite = 0; e_paddr = '0; e_pwdata = '0;
         e_done = '0; e_err = '0; e_rdata[0] = '0; e_rdata[1] = '0;
      end else begin
         e_done = '0;
         if (!m_busy) begin
            if (req0_i || req1_i) begin
               g = (req0_i && req1_i) ? !m_last : req1_i;
               m_last = g; m_own = g; m_busy = 1; m_acc = 0; m_wait = 0;
               e_pwrite = g ? wr1_i : wr0_i;
               e_paddr  = g ? addr1_i : addr0_i;
               e_pwdata = g ? wdata1_i : wdata0_i;
            end
         end else if (!m_acc) m_acc = 1;
         else if (pready_i || m_wait + 1 == TO) begin
            m_busy = 0; m_acc = 0;
            e_done[m_own] = 1'b1;
            e_err[m_own]  = pready_i ? pslverr_i : 1'b1;
            if (pready_i && !e_pwrite) e_rdata[m_own] = prdata_i;
         end else m_wait++;
      end
      e_psel = m_busy;
      e_pen  = m_busy && m_acc;
   endtask

   task automatic check_all();
      chk("psel", psel_o, e_psel);
      chk("penable", penable_o, e_pen);
      chk("pwrite", pwrite_o, e_pwrite);
      chk("paddr", paddr_o, e_paddr);
      chk("pwdata", pwdata_o, e_pwdata);
      chk("done0", done0_o, e_done[0]);
      chk("done1", done1_o, e_done[1]);
      chk("rdata0", rdata0_o, e_rdata[0]);
      chk("rdata1", rdata1_o, e_rdata[1]);
      if (e_done[0]) chk("err0", err0_o, e_err[0]);
      if (e_done[1]) chk("err1", err1_o, e_err[1]);
   endtask

   // one clock: behave as the slave, advance the model, then compare
   task automatic cyc();
      pready_i = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? 1'b0 : (stall > 0) ? 1'b0 : ($urandom % 3 != 0);
      if (stall > 0) stall--;
      else if (rdy_mode == 2 && $urandom % 60 == 0) stall = 20;
      prdata_i  = force_prd_en ? force_prd : mem[paddr_o];
      pslverr_i = (err_addr_en && paddr_o == 8'd2) || (rand_err && $urandom % 8 == 0);
      if (psel_o && penable_o && pwrite_o && pready_i) mem[paddr_o] = pwdata_o;
      @(posedge pclk_i_tb);
      model_step();
      #1;
      check_all();
      psel_cnt += int'(psel_o);
      pen_cnt  += int'(penable_o);
      if (done0_o) begin d0_cnt++; order.push_back(0); end
      if (done1_o) begin d1_cnt++; order.push_back(1); end
   endtask

   task automatic run_until_done(input int p);
      int k = 0;
      do begin
         cyc();
         k++;
      end while (!(p == 1 ? done1_o : done0_o) && k < 40);
      chk(p == 1 ? "wait_done1" : "wait_done0", p == 1 ? done1_o : done0_o, 1);
   endtask

   initial begin
      int k;
      preset_i = 1; req0_i = 0; req1_i = 0; wr0_i = 0; wr1_i = 0;
      addr0_i = '0; addr1_i = '0; wdata0_i = '0; wdata1_i = '0;
      prdata_i = '0; pready_i = 0; pslverr_i = 0;
      for (int i = 0; i < 256; i++) mem[i] = '0;
      rdy_mode = 0; stall = 0; err_addr_en = 0; rand_err = 0; force_prd_en = 0; force_prd = '0;
      psel_cnt = 0; pen_cnt = 0; d0_cnt = 0; d1_cnt = 0;
      #2;
      cyc(); cyc();
      preset_i = 0;
      chk("rst_psel", psel_o, 0);
      chk("rst_pwrite", pwrite_o, 0);
      chk("rst_paddr", paddr_o, 0);
      chk("rst_err0", err0_o, 0);
      chk("rst_err1", err1_o, 0);
      chk("rst_rdata0", rdata0_o, 0);

      // ties from reset alternate starting with port 0
      req0_i = 1; req1_i = 1; wr0_i = 1; wr1_i = 1;
      addr0_i = 8'h10; addr1_i = 8'h11; wdata0_i = 32'h100; wdata1_i = 32'h101;
      order.delete();
      k = 0;
      while (order.size() < 4 && k < 40) begin cyc(); k++; end
      req0_i = 0; req1_i = 0;
      chk("rr_count", order.size(), 4);
      for (int i = 0; i < order.size() && i < 4; i++) chk("rr_order", order[i], i % 2);
      cyc(); cyc();

      // port 0 write, slave ready at once
      psel_cnt = 0; pen_cnt = 0; d0_cnt = 0;
      req0_i = 1; wr0_i = 1; addr0_i = 8'd1; wdata0_i = 32'd15;
      run_until_done(0);
      chk("wr_err0", err0_o, 0);
      req0_i = 0;
      cyc(); cyc();
      chk("wr_psel_cycles", psel_cnt, 2);
      chk("wr_pen_cycles", pen_cnt, 1);
      chk("wr_done_pulses", d0_cnt, 1);

      // port 1 reads back the write
      req1_i = 1; wr1_i = 0; addr1_i = 8'd1;
      run_until_done(1);
      chk("rd_rdata1", rdata1_o, 32'd15);
      chk("rd_rdata0", rdata0_o, 0);
      req1_i = 0;
      cyc();

      // slave never ready: timeout after TO access cycles
      rdy_mode = 1; pen_cnt = 0;
      req0_i = 1; wr0_i = 0; addr0_i = 8'd3;
      run_until_done(0);
      chk("to_pen_cycles", pen_cnt, 16);
      chk("to_err0", err0_o, 1);
      chk("to_rdata0", rdata0_o, 0);
      req0_i = 0;
      cyc();
      chk("to_psel_after", psel_o, 0);
      rdy_mode = 0;

      // slave error on read of address 2
      err_addr_en = 1; force_prd_en = 1; force_prd = 32'hABCD1234;
      req1_i = 1; wr1_i = 0; addr1_i = 8'd2;
      run_until_done(1);
      chk("se_err1", err1_o, 1);
      chk("se_rdata1", rdata1_o, 32'hABCD1234);
      req1_i = 0; err_addr_en = 0; force_prd_en = 0;
      cyc();

      // reset in ACCESS aborts silently and restores port 0 priority
      rdy_mode = 1;
      req0_i = 1; wr0_i = 0; addr0_i = 8'd5;
      k = 0;
      do begin cyc(); k++; end while (!penable_o && k < 10);
      chk("ab_in_access", penable_o, 1);
      preset_i = 1; req0_i = 0;
      cyc();
      chk("ab_psel", psel_o, 0);
      chk("ab_penable", penable_o, 0);
      chk("ab_done0", done0_o, 0);
      preset_i = 0; rdy_mode = 0;
      req0_i = 1; req1_i = 1; addr0_i = 8'h40; addr1_i = 8'h41;
      cyc();
      chk("ab_tie_addr", paddr_o, 8'h40);
      run_until_done(0);
      req0_i = 0; req1_i = 0;
      cyc(); cyc();

      // randomized traffic
      rdy_mode = 2; rand_err = 1;
      repeat (3000) begin
         if (!req0_i && $urandom % 3 == 0) begin
            req0_i = 1; wr0_i = 1'($urandom % 2); addr0_i = 8'($urandom % 8); wdata0_i = $urandom;
         end
         if (!req1_i && $urandom % 3 == 0) begin
            req1_i = 1; wr1_i = 1'($urandom % 2); addr1_i = 8'($urandom % 8); wdata1_i = $urandom;
         end
         if (req0_i && psel_o && $urandom % 20 == 0) req0_i = 0;
         if (req1_i && psel_o && $urandom % 20 == 0) req1_i = 0;
         preset_i = ($urandom % 300 == 0);
         cyc();
         if (done0_o) req0_i = 0;
         if (done1_o) req1_i = 0;
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
